mmd_frac_divider: RTL and testbench
===================================

// Module: mmd_frac_divider
// PURPOSE
//  Multi-modulus counter divider; consumer end of the 3rd-order DDSM.
//  Each output period divides clk by N = n_int + sdm_in, sampling one signed DDSM word per period.
//  Issues sdm_tick as the DDSM clock-enable; the integer and fractional control words together set the average division ratio.
//  Sits between the DDSM and the fractional frequency divider output.
// PARAMETERS
//  W        8   width of n_int, modulus and internal down-counter
//  MIN_MOD  4   smallest legal modulus; lower results are clamped up to it
// PORTS
//  clk       in   1  single clock; all logic on posedge
//  rst       in   1  synchronous, active-low reset
//  en        in   1  run enable; low forces IDLE
//  n_int     in   W  integer division ratio, unsigned
//  sdm_in    in   4  signed DDSM offset, two's complement, legal -3..+4
//  sdm_tick  out  1  one-cycle strobe: sdm_in consumed, DDSM must advance
//  div_pulse out  1  one-cycle pulse at each period end (terminal count)
//  div_out   out  1  divided clock, high for first ceil(mod/2) cycles of period
//  cur_mod   out  W  modulus of the period currently running
//  clamped   out  1  high for the period whose modulus was clamped
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE, cnt=0, cur_mod=0, all 1-bit outputs 0; wins over en.
//  States: IDLE -> LOAD when en==1; LOAD -> RUN (1 cycle); RUN -> IDLE when en==0 at any posedge.
//  LOAD: nxt = clamp(n_int + sext(sdm_in)); cur_mod<=nxt, cnt<=nxt-1, sdm_tick=1.
//  Modulus arithmetic in W+2-bit signed; clamp low to MIN_MOD, high to 2^W-1; clamped=1 if either.
//  RUN, cnt>0: cnt<=cnt-1.
//  RUN, cnt==0 (terminal): div_pulse=1, sdm_tick=1, reload cur_mod/cnt from current n_int, sdm_in.
//  Back-to-back periods: no idle cycle; period length = cur_mod clk cycles exactly.
//  div_out = 1 while cnt >= floor(cur_mod/2) in RUN, else 0; registered, so it lags cnt by one cycle.
//  sdm_tick, div_pulse combinational from registered state; sdm_in sampled in the same cycle.
//  n_int change mid-period: no effect until next reload.
//  sdm_in outside -3..+4: still added, then clamped; no other error action.
//  en dropped mid-period: IDLE next cycle, cnt/cur_mod cleared, no div_pulse, period discarded.
//  en reasserted: fresh LOAD, one new sdm_tick; DDSM stays in lockstep (one tick per period).
//  n_int=0 or 1 with negative sdm_in: clamps to MIN_MOD, clamped=1.
//  Latency: en rise -> first div_pulse after 1 + cur_mod cycles.
// CONFIGURATION
//  FFD_CLAMP_STICKY_EN defined: adds output clamp_err (1 bit).
//   - Sets on any clamp; clears only on reset.
//   - Also adds 16-bit saturating output clamp_cnt, counting clamp events.
//  Undefined: no extra ports; clamped remains per-period only.
// TESTING
//  rst=0 3 cycles then rst=1, en=0 -> all outputs 0, cur_mod=0.
//  n_int=10, sdm_in=0, en=1 -> div_pulse every 10 clk, div_out 5 high/5 low, sdm_tick with each pulse.
//  n_int=10, sdm_in seq +4,-3,+1 -> periods 14,7,11 clk, sdm_tick count = period count.
//  n_int=5, sdm_in=-3 -> cur_mod=4 (MIN_MOD), clamped=1; clamp_err=1 with FFD_CLAMP_STICKY_EN.
//  n_int=255, sdm_in=+4 -> cur_mod=255, clamped=1.
//  en=0 at cnt=3 of 10 -> IDLE next cycle, no div_pulse; en=1 -> LOAD, first pulse after 11 clk.
//  rst=0 mid-RUN with en=1 -> outputs 0 next cycle; resume from LOAD after rst=1.

Source files
------------

// File: rtl/mmd_frac_divider.sv
// Multi-modulus counter divider: divides clk by n_int + signed DDSM offset, one DDSM word per period.
// Optional FFD_CLAMP_STICKY_EN adds sticky clamp_err and saturating clamp_cnt outputs.
module mmd_frac_divider #(
  parameter int W       = 8,
  parameter int MIN_MOD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] n_int,
  input  logic [3:0]   sdm_in,
  output logic         sdm_tick,
  output logic         div_pulse,
  output logic         div_out,
  output logic [W-1:0] cur_mod,
  output logic         clamped
`ifdef FFD_CLAMP_STICKY_EN
  ,
  output logic         clamp_err,
  output logic [15:0]  clamp_cnt
`endif
);

  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] MIN_S = SW'(MIN_MOD);
  localparam logic signed [SW-1:0] MAX_S = SW'((2 ** W) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_cnt, w_cnt_nxt;
  logic [W-1:0]    r_cur_mod, w_mod_nxt;
  logic            r_div_out, w_div_out_nxt;
  logic            r_clamped, w_clamped_nxt;
  logic            w_load;
  logic            w_terminal;
  logic signed [SW-1:0] w_sum;
  logic [W-1:0]    w_mod_calc;
  logic            w_clamp;

  // Sum in a wider signed domain so negative offsets and overflow past 2^W-1 are both visible.
  always_comb begin
    w_sum      = $signed({2'b00, n_int}) + SW'($signed(sdm_in));
    w_mod_calc = w_sum[W-1:0];
    w_clamp    = 1'b0;
    if (w_sum < MIN_S) begin
      w_mod_calc = W'(MIN_MOD);
      w_clamp    = 1'b1;
    end else if (w_sum > MAX_S) begin
      w_mod_calc = '1;
      w_clamp    = 1'b1;
    end
  end

  assign w_terminal = (r_state == RUN) && (r_cnt == '0);
  assign sdm_tick   = (r_state == LOAD) || w_terminal;
  assign div_pulse  = w_terminal;
  assign div_out    = r_div_out;
  assign cur_mod    = r_cur_mod;
  assign clamped    = r_clamped;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mod_nxt     = r_cur_mod;
    w_clamped_nxt = r_clamped;
    w_div_out_nxt = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt     = '0;
        w_mod_nxt     = '0;
        w_clamped_nxt = 1'b0;
        if (en) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_mod_nxt     = '0;
          w_clamped_nxt = 1'b0;
        end else begin
          w_div_out_nxt = (r_cnt >= (r_cur_mod >> 1));
          if (r_cnt == '0) w_load = 1'b1;
          else             w_cnt_nxt = r_cnt - W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_mod_nxt     = w_mod_calc;
      w_cnt_nxt     = w_mod_calc - W'(1);
      w_clamped_nxt = w_clamp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cur_mod <= '0;
      r_div_out <= 1'b0;
      r_clamped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_mod <= w_mod_nxt;
      r_div_out <= w_div_out_nxt;
      r_clamped <= w_clamped_nxt;
    end
  end

`ifdef FFD_CLAMP_STICKY_EN
  logic        r_clamp_err;
  logic [15:0] r_clamp_cnt;

  // Only loads that actually start a period count as clamp events.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clamp_err <= 1'b0;
      r_clamp_cnt <= '0;
    end else if (w_load && w_clamp) begin
      r_clamp_err <= 1'b1;
      if (r_clamp_cnt != '1) r_clamp_cnt <= r_clamp_cnt + 16'd1;
    end
  end

  assign clamp_err = r_clamp_err;
  assign clamp_cnt = r_clamp_cnt;
`endif

endmodule

// File: tb/tb_mmd_frac_divider.sv
// Scoreboard bench for mmd_frac_divider: expected periods queued with stimulus, checked at each div_pulse.
module tb_mmd_frac_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] n_int  = '0;
  logic [3:0] sdm_in = '0;
  logic       sdm_tick, div_pulse, div_out, clamped;
  logic [7:0] cur_mod;
`ifdef FFD_CLAMP_STICKY_EN
  logic        clamp_err;
  logic [15:0] clamp_cnt;
`endif

  always #5 clk = ~clk;

  mmd_frac_divider #(.W(8), .MIN_MOD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .n_int     (n_int),
    .sdm_in    (sdm_in),
    .sdm_tick  (sdm_tick),
    .div_pulse (div_pulse),
    .div_out   (div_out),
    .cur_mod   (cur_mod),
    .clamped   (clamped)
`ifdef FFD_CLAMP_STICKY_EN
    ,
    .clamp_err (clamp_err),
    .clamp_cnt (clamp_cnt)
`endif
  );

  typedef struct {int mod; int clp;} exp_t;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] sdm_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, pulse_cnt = 0, tick_cnt = 0;
  int last_tick_cyc = 0, last_pulse_cyc = 0, hi = 0;
  bit pop_pend = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void refresh_sdm();
    sdm_in = (sdm_q.size() > 0) ? sdm_q[0] : 4'd0;
  endfunction

  task automatic push_sdm_only(input int s);
    sdm_q.push_back(4'(s));
    refresh_sdm();
  endtask

  task automatic push_period(input int n, input int s);
    int sum;
    exp_t e;
    sum = n + s;
    if (sum < 4)        e = '{4, 1};
    else if (sum > 255) e = '{255, 1};
    else                e = '{sum, 0};
    exp_q.push_back(e);
    push_sdm_only(s);
  endtask

  // DDSM model advances after the edge that consumed sdm_in; monitor checks each finished period.
  always @(negedge clk) begin
    cyc++;
    if (pop_pend) begin
      if (sdm_q.size() > 0) void'(sdm_q.pop_front());
      refresh_sdm();
      pop_pend = 1'b0;
    end
    hi += int'(div_out);
    if (div_pulse) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period_len", cyc - last_tick_cyc, mon_e.mod);
        check("cur_mod", int'(cur_mod), mon_e.mod);
        check("clamped", int'(clamped), mon_e.clp);
        check("div_out_high", hi, (mon_e.mod + 1) / 2);
      end
    end
    if (sdm_tick) begin
      tick_cnt++;
      last_tick_cyc = cyc;
      hi = 0;
      pop_pend = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int t = 0;
    while (pulse_cnt < target && t < budget) begin
      step();
      t++;
    end
    if (pulse_cnt < target) check({tag, "_timeout"}, pulse_cnt, target);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cur_mod"},   int'(cur_mod),   0);
    check({tag, "_div_out"},   int'(div_out),   0);
    check({tag, "_sdm_tick"},  int'(sdm_tick),  0);
    check({tag, "_div_pulse"}, int'(div_pulse), 0);
    check({tag, "_clamped"},   int'(clamped),   0);
  endtask

  task automatic run(input int n, input int k, input int lat, input string tag);
    int p0, t0, c0;
    n_int = 8'(n);
    p0 = pulse_cnt;
    t0 = tick_cnt;
    c0 = cyc;
    en = 1'b1;
    wait_pulses(p0 + 1, lat + 5, tag);
    check({tag, "_latency"}, last_pulse_cyc - c0, lat);
    wait_pulses(p0 + k, k * 300, tag);
    en = 1'b0;
    check({tag, "_ticks"}, tick_cnt - t0, k + 1);
    step();
    step();
    check({tag, "_idle_mod"}, int'(cur_mod), 0);
    check({tag, "_idle_div"}, int'(div_out), 0);
  endtask

  initial begin
    int t0, p0, c0, tb;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_idle("reset");

    repeat (3) push_period(10, 0);
    run(10, 3, 11, "n10");

    push_period(10, 4);
    push_period(10, -3);
    push_period(10, 1);
    run(10, 3, 15, "seq");

    repeat (2) push_period(5, -3);
    run(5, 2, 5, "clamp_lo");

    repeat (2) push_period(255, 4);
    run(255, 2, 256, "clamp_hi");

    push_period(0, -3);
    run(0, 1, 5, "n0");
    push_period(1, -2);
    run(1, 1, 5, "n1");

    push_period(20, -8);
    push_period(20, 7);
    run(20, 2, 13, "wide_sdm");

    // Drop en with cnt at 3 of 10: no pulse, then a fresh period with one new tick.
    n_int = 8'd10;
    push_sdm_only(0);
    push_period(10, 0);
    t0 = tick_cnt;
    en = 1'b1;
    tb = 0;
    while (tick_cnt == t0 && tb < 5) begin
      step();
      tb++;
    end
    check("abort_load_tick", tick_cnt - t0, 1);
    p0 = pulse_cnt;
    repeat (7) step();
    en = 1'b0;
    step();
    check_idle("abort");
    repeat (12) step();
    check("abort_no_pulse", pulse_cnt, p0);
    run(10, 1, 11, "reen");

`ifdef FFD_CLAMP_STICKY_EN
    check("clamp_err_set", int'(clamp_err), 1);
    check("clamp_cnt", int'(clamp_cnt), 6);
`endif

    // Reset during RUN with en held high, then resume from LOAD.
    n_int = 8'd12;
    push_sdm_only(0);
    push_period(12, 0);
    en = 1'b1;
    repeat (6) step();
    rst = 1'b0;
    step();
    check_idle("midrst");
`ifdef FFD_CLAMP_STICKY_EN
    check("clamp_err_clr", int'(clamp_err), 0);
`endif
    rst = 1'b1;
    c0 = cyc;
    p0 = pulse_cnt;
    wait_pulses(p0 + 1, 20, "midrst");
    check("midrst_latency", last_pulse_cyc - c0, 13);
    en = 1'b0;
    step();
    step();

    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
